// File: rtl/issue_ctrl_pkg.sv
// Shared types and constants for the decode/issue controller.
// Operand-use classification is keyed on the RV32I major opcode.
package issue_ctrl_pkg;

    localparam int unsigned ILEN  = 32;
    localparam int unsigned NREGS = 32;
    localparam int unsigned RegW  = $clog2(NREGS);

    // U and J groups
    localparam logic [6:0] OpLui    = 7'b0110111;
    localparam logic [6:0] OpAuipc  = 7'b0010111;
    localparam logic [6:0] OpJal    = 7'b1101111;
    // B and S groups
    localparam logic [6:0] OpBranch = 7'b1100011;
    localparam logic [6:0] OpStore  = 7'b0100011;
    // I group
    localparam logic [6:0] OpJalr   = 7'b1100111;
    localparam logic [6:0] OpLoad   = 7'b0000011;
    localparam logic [6:0] OpImm    = 7'b0010011;
    localparam logic [6:0] OpFence  = 7'b0001111;
    localparam logic [6:0] OpSystem = 7'b1110011;
    // R group
    localparam logic [6:0] OpReg    = 7'b0110011;

    typedef struct packed {
        logic uses_rs1;
        logic uses_rs2;
        logic uses_rd;
    } operand_use_t;

    typedef enum logic {
        StEmpty,
        StHeld
    } issue_state_t;

    function automatic operand_use_t decode_use(logic [6:0] opcode);
        operand_use_t u;
        u = '0;
        case (opcode)
            OpLui, OpAuipc, OpJal: u.uses_rd = 1'b1;
            OpBranch, OpStore: begin
                u.uses_rs1 = 1'b1;
                u.uses_rs2 = 1'b1;
            end
            OpJalr, OpLoad, OpImm, OpFence, OpSystem: begin
                u.uses_rd  = 1'b1;
                u.uses_rs1 = 1'b1;
            end
            OpReg: begin
                u.uses_rd  = 1'b1;
                u.uses_rs1 = 1'b1;
                u.uses_rs2 = 1'b1;
            end
            default: u = '0;
        endcase
        return u;
    endfunction

endpackage

// File: rtl/issue_ctrl_if.sv
// Fetch, execute, writeback and flush signals of the issue controller.
// slave is the controller side, master is the environment side.
interface issue_ctrl_if;
    import issue_ctrl_pkg::*;

    logic             instr_valid;
    logic             instr_ready;
    logic [ILEN-1:0]  instr;
    logic             issue_valid;
    logic             issue_ready;
    logic [ILEN-1:0]  issue_instr;
    logic             wb_valid;
    logic [RegW-1:0]  wb_rd;
    logic             flush;
    logic             hazard;
    logic [NREGS-1:0] busy_regs;

    modport slave (
        input  instr_valid, instr, issue_ready, wb_valid, wb_rd, flush,
        output instr_ready, issue_valid, issue_instr, hazard, busy_regs
    );

    modport master (
        output instr_valid, instr, issue_ready, wb_valid, wb_rd, flush,
        input  instr_ready, issue_valid, issue_instr, hazard, busy_regs
    );

endinterface

// File: rtl/issue_ctrl_scoreboard.sv
// Busy-bit scoreboard for in-flight destination registers (module issue_scoreboard).
// Optional ISSUE_WB_BYPASS_EN masks the same-cycle writeback out of the lookup.
module issue_scoreboard
    import issue_ctrl_pkg::*;
(
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             set_i,
    input  logic [RegW-1:0]  set_idx_i,
    input  logic             clr_i,
    input  logic [RegW-1:0]  clr_idx_i,
    input  logic [RegW-1:0]  rs1_idx_i,
    input  logic [RegW-1:0]  rs2_idx_i,
    input  logic [RegW-1:0]  rd_idx_i,
    output logic             busy_rs1_o,
    output logic             busy_rs2_o,
    output logic             busy_rd_o,
    output logic [NREGS-1:0] busy_o
);

    localparam logic [NREGS-1:0] OneHot0 = NREGS'(1);

    logic [NREGS-1:0] busy_d, busy_q;
    logic [NREGS-1:0] lookup;

    // Set is applied after clear so a collision leaves the bit set.
    always_comb begin
        busy_d = busy_q;
        if (clr_i) busy_d[clr_idx_i] = 1'b0;
        if (set_i) busy_d[set_idx_i] = 1'b1;
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) busy_q <= '0;
        else         busy_q <= busy_d;
    end

    always_comb begin
`ifdef ISSUE_WB_BYPASS_EN
        lookup = busy_q & ~(clr_i ? (OneHot0 << clr_idx_i) : '0);
`else
        lookup = busy_q;
`endif
    end

    assign busy_rs1_o = lookup[rs1_idx_i];
    assign busy_rs2_o = lookup[rs2_idx_i];
    assign busy_rd_o  = lookup[rd_idx_i];
    assign busy_o     = busy_q;

endmodule

// File: rtl/issue_ctrl.sv
// Decode/issue controller: holds one instruction and stalls it on RAW/WAW scoreboard hazards.
// Define ISSUE_WB_BYPASS_EN to let a stalled instruction issue alongside its clearing writeback.
module issue_ctrl
    import issue_ctrl_pkg::*;
(
    input  logic        clk_i,
    input  logic        reset_i,
    issue_ctrl_if.slave bus
);

    issue_state_t    state_d, state_q;
    logic [ILEN-1:0] instr_d, instr_q;
    operand_use_t    use_q;
    logic            busy_rs1, busy_rs2, busy_rd;
    logic            hazard, issue_valid, instr_ready, fire;

    assign use_q = decode_use(instr_q[6:0]);

    issue_scoreboard u_scoreboard (
        .clk_i      (clk_i),
        .reset_i    (reset_i),
        .set_i      (fire & use_q.uses_rd),
        .set_idx_i  (instr_q[11:7]),
        .clr_i      (bus.wb_valid),
        .clr_idx_i  (bus.wb_rd),
        .rs1_idx_i  (instr_q[19:15]),
        .rs2_idx_i  (instr_q[24:20]),
        .rd_idx_i   (instr_q[11:7]),
        .busy_rs1_o (busy_rs1),
        .busy_rs2_o (busy_rs2),
        .busy_rd_o  (busy_rd),
        .busy_o     (bus.busy_regs)
    );

    always_comb begin
        state_d     = state_q;
        instr_d     = instr_q;
        hazard      = 1'b0;
        issue_valid = 1'b0;
        instr_ready = 1'b0;
        fire        = 1'b0;
        if (!reset_i) begin
            if (state_q == StHeld) begin
                hazard = (use_q.uses_rs1 & busy_rs1) | (use_q.uses_rs2 & busy_rs2) |
                         (use_q.uses_rd & busy_rd);
            end
            if (bus.flush) begin
                // Offered instruction is consumed and dropped together with the held one.
                instr_ready = 1'b1;
                state_d     = StEmpty;
            end else begin
                unique case (state_q)
                    StEmpty: begin
                        instr_ready = 1'b1;
                        if (bus.instr_valid) begin
                            instr_d = bus.instr;
                            state_d = StHeld;
                        end
                    end
                    StHeld: begin
                        issue_valid = !hazard;
                        fire        = issue_valid & bus.issue_ready;
                        instr_ready = fire;
                        if (fire) begin
                            if (bus.instr_valid) instr_d = bus.instr;
                            else                 state_d = StEmpty;
                        end
                    end
                    default: state_d = StEmpty;
                endcase
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= StEmpty;
            instr_q <= '0;
        end else begin
            state_q <= state_d;
            instr_q <= instr_d;
        end
    end

    assign bus.hazard      = hazard;
    assign bus.issue_valid = issue_valid;
    assign bus.instr_ready = instr_ready;
    assign bus.issue_instr = instr_q;

endmodule

// File: tb/tb_issue_ctrl.sv
// Directed bench for issue_ctrl; expectations follow ISSUE_WB_BYPASS_EN when defined.
// Inputs change at the falling edge, outputs are sampled 1ns later, before the rising edge.
module tb_issue_ctrl;
    import issue_ctrl_pkg::*;

    localparam logic [31:0] AddiX1   = 32'h0050_0093; // addi x1,x0,5
    localparam logic [31:0] AddiX2   = 32'h0070_0113; // addi x2,x0,7
    localparam logic [31:0] AddiX3   = 32'h0010_0193; // addi x3,x0,1
    localparam logic [31:0] AddX4    = 32'h0031_8233; // add x4,x3,x3
    localparam logic [31:0] LuiX5    = 32'h1234_52B7; // lui x5,0x12345
    localparam logic [31:0] AddiX0   = 32'h0010_0013; // addi x0,x0,1
    localparam logic [31:0] SwX0     = 32'h0000_2023; // sw x0,0(x0)

    logic clk;
    logic reset;
    int   n_checks;
    int   n_fail;

    issue_ctrl_if bus ();

    issue_ctrl dut (
        .clk_i   (clk),
        .reset_i (reset),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic idle_inputs();
        bus.instr_valid = 1'b0;
        bus.instr       = '0;
        bus.issue_ready = 1'b0;
        bus.wb_valid    = 1'b0;
        bus.wb_rd       = '0;
        bus.flush       = 1'b0;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        idle_inputs();
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    // Drive one instruction offer at the next falling edge.
    task automatic offer(input logic v, input logic [31:0] ins);
        @(negedge clk);
        bus.instr_valid = v;
        bus.instr       = ins;
        #1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        idle_inputs();
        reset = 1'b1;
        bus.instr_valid = 1'b1;
        bus.instr = AddiX1;
        #1;
        n_checks++;
        if (bus.instr_ready !== 1'b0) begin
            n_fail++; $display("FAIL reset_instr_ready got %b want 0", bus.instr_ready);
        end
        n_checks++;
        if (bus.issue_valid !== 1'b0 || bus.hazard !== 1'b0) begin
            n_fail++; $display("FAIL reset_outputs got iv=%b hz=%b want 0 0", bus.issue_valid, bus.hazard);
        end
        @(negedge clk);
        bus.instr_valid = 1'b0;
        #1;
        n_checks++;
        if (bus.busy_regs !== 32'h0 || bus.issue_instr !== 32'h0) begin
            n_fail++; $display("FAIL reset_regs got busy=%h instr=%h want 0 0", bus.busy_regs, bus.issue_instr);
        end
        reset = 1'b0;
    endtask

    task automatic test_back_to_back();
        apply_reset();
        bus.issue_ready = 1'b1;
        offer(1'b1, AddiX1);
        n_checks++;
        if (bus.instr_ready !== 1'b1 || bus.issue_valid !== 1'b0) begin
            n_fail++; $display("FAIL b2b_empty got rdy=%b iv=%b want 1 0", bus.instr_ready, bus.issue_valid);
        end
        offer(1'b1, AddiX2);
        n_checks++;
        if (bus.issue_valid !== 1'b1 || bus.issue_instr !== AddiX1 || bus.instr_ready !== 1'b1) begin
            n_fail++; $display("FAIL b2b_first got iv=%b instr=%h rdy=%b want 1 %h 1",
                               bus.issue_valid, bus.issue_instr, bus.instr_ready, AddiX1);
        end
        offer(1'b0, '0);
        n_checks++;
        if (bus.issue_valid !== 1'b1 || bus.issue_instr !== AddiX2 || bus.busy_regs !== 32'h2) begin
            n_fail++; $display("FAIL b2b_second got iv=%b instr=%h busy=%h want 1 %h 2",
                               bus.issue_valid, bus.issue_instr, bus.busy_regs, AddiX2);
        end
        offer(1'b0, '0);
        n_checks++;
        if (bus.issue_valid !== 1'b0 || bus.busy_regs !== 32'h6) begin
            n_fail++; $display("FAIL b2b_done got iv=%b busy=%h want 0 6", bus.issue_valid, bus.busy_regs);
        end
    endtask

    task automatic test_raw_stall();
        apply_reset();
        bus.issue_ready = 1'b1;
        offer(1'b1, AddiX3);
        offer(1'b1, AddX4);
        offer(1'b0, '0);
        n_checks++;
        if (bus.hazard !== 1'b1 || bus.issue_valid !== 1'b0 || bus.busy_regs !== 32'h8) begin
            n_fail++; $display("FAIL raw_stall got hz=%b iv=%b busy=%h want 1 0 8",
                               bus.hazard, bus.issue_valid, bus.busy_regs);
        end
        offer(1'b0, '0);
        n_checks++;
        if (bus.hazard !== 1'b1 || bus.issue_instr !== AddX4) begin
            n_fail++; $display("FAIL raw_hold got hz=%b instr=%h want 1 %h", bus.hazard, bus.issue_instr, AddX4);
        end
        @(negedge clk);
        bus.wb_valid = 1'b1;
        bus.wb_rd    = 5'd3;
        #1;
`ifdef ISSUE_WB_BYPASS_EN
        n_checks++;
        if (bus.hazard !== 1'b0 || bus.issue_valid !== 1'b1) begin
            n_fail++; $display("FAIL raw_wb_cycle got hz=%b iv=%b want 0 1", bus.hazard, bus.issue_valid);
        end
        @(negedge clk);
        bus.wb_valid = 1'b0;
        #1;
        n_checks++;
        if (bus.issue_valid !== 1'b0 || bus.busy_regs !== 32'h10) begin
            n_fail++; $display("FAIL raw_after got iv=%b busy=%h want 0 10", bus.issue_valid, bus.busy_regs);
        end
`else
        n_checks++;
        if (bus.hazard !== 1'b1 || bus.issue_valid !== 1'b0) begin
            n_fail++; $display("FAIL raw_wb_cycle got hz=%b iv=%b want 1 0", bus.hazard, bus.issue_valid);
        end
        @(negedge clk);
        bus.wb_valid = 1'b0;
        #1;
        n_checks++;
        if (bus.hazard !== 1'b0 || bus.issue_valid !== 1'b1 || bus.busy_regs !== 32'h0) begin
            n_fail++; $display("FAIL raw_release got hz=%b iv=%b busy=%h want 0 1 0",
                               bus.hazard, bus.issue_valid, bus.busy_regs);
        end
        @(negedge clk);
        #1;
        n_checks++;
        if (bus.issue_valid !== 1'b0 || bus.busy_regs !== 32'h10) begin
            n_fail++; $display("FAIL raw_after got iv=%b busy=%h want 0 10", bus.issue_valid, bus.busy_regs);
        end
`endif
    endtask

    task automatic test_collision();
        apply_reset();
        bus.issue_ready = 1'b1;
        offer(1'b1, LuiX5);
        @(negedge clk);
        bus.instr_valid = 1'b0;
        bus.wb_valid    = 1'b1;
        bus.wb_rd       = 5'd5;
        #1;
        n_checks++;
        if (bus.issue_valid !== 1'b1) begin
            n_fail++; $display("FAIL coll_issue got iv=%b want 1", bus.issue_valid);
        end
        @(negedge clk);
        bus.wb_valid = 1'b0;
        #1;
        n_checks++;
        if (bus.busy_regs !== 32'h20) begin
            n_fail++; $display("FAIL coll_busy got busy=%h want 20", bus.busy_regs);
        end
    endtask

    task automatic test_flush();
        apply_reset();
        bus.issue_ready = 1'b1;
        offer(1'b1, AddiX3);
        offer(1'b1, AddX4);
        offer(1'b0, '0);
        @(negedge clk);
        bus.flush       = 1'b1;
        bus.instr_valid = 1'b1;
        bus.instr       = AddiX1;
        #1;
        n_checks++;
        if (bus.instr_ready !== 1'b1 || bus.issue_valid !== 1'b0) begin
            n_fail++; $display("FAIL flush_cycle got rdy=%b iv=%b want 1 0", bus.instr_ready, bus.issue_valid);
        end
        @(negedge clk);
        bus.flush       = 1'b0;
        bus.instr_valid = 1'b0;
        #1;
        n_checks++;
        if (bus.issue_valid !== 1'b0 || bus.hazard !== 1'b0 || bus.instr_ready !== 1'b1 ||
            bus.busy_regs !== 32'h8) begin
            n_fail++; $display("FAIL flush_after got iv=%b hz=%b rdy=%b busy=%h want 0 0 1 8",
                               bus.issue_valid, bus.hazard, bus.instr_ready, bus.busy_regs);
        end
    endtask

    task automatic test_x0();
        apply_reset();
        bus.issue_ready = 1'b1;
        offer(1'b1, AddiX0);
        offer(1'b1, SwX0);
        n_checks++;
        if (bus.issue_valid !== 1'b1 || bus.issue_instr !== AddiX0) begin
            n_fail++; $display("FAIL x0_addi got iv=%b instr=%h want 1 %h", bus.issue_valid, bus.issue_instr, AddiX0);
        end
        @(negedge clk);
        bus.instr_valid = 1'b0;
        bus.wb_valid    = 1'b1;
        bus.wb_rd       = 5'd0;
        #1;
        n_checks++;
        if (bus.issue_valid !== 1'b1 || bus.hazard !== 1'b0 || bus.busy_regs !== 32'h0) begin
            n_fail++; $display("FAIL x0_sw got iv=%b hz=%b busy=%h want 1 0 0",
                               bus.issue_valid, bus.hazard, bus.busy_regs);
        end
        @(negedge clk);
        bus.wb_valid = 1'b0;
        #1;
        n_checks++;
        if (bus.busy_regs !== 32'h0 || bus.issue_valid !== 1'b0) begin
            n_fail++; $display("FAIL x0_after got busy=%h iv=%b want 0 0", bus.busy_regs, bus.issue_valid);
        end
    endtask

    task automatic test_reset_mid_stall();
        apply_reset();
        bus.issue_ready = 1'b1;
        offer(1'b1, AddiX1);
        offer(1'b1, AddiX2);
        offer(1'b1, AddiX3);
        offer(1'b1, AddX4);
        offer(1'b0, '0);
        n_checks++;
        if (bus.hazard !== 1'b1 || bus.busy_regs !== 32'hE) begin
            n_fail++; $display("FAIL rst_stall_pre got hz=%b busy=%h want 1 e", bus.hazard, bus.busy_regs);
        end
        @(negedge clk);
        reset = 1'b1;
        #1;
        n_checks++;
        if (bus.issue_valid !== 1'b0 || bus.instr_ready !== 1'b0 || bus.hazard !== 1'b0) begin
            n_fail++; $display("FAIL rst_stall_during got iv=%b rdy=%b hz=%b want 0 0 0",
                               bus.issue_valid, bus.instr_ready, bus.hazard);
        end
        @(negedge clk);
        reset = 1'b0;
        #1;
        n_checks++;
        if (bus.busy_regs !== 32'h0 || bus.issue_valid !== 1'b0 || bus.instr_ready !== 1'b1 ||
            bus.issue_instr !== 32'h0) begin
            n_fail++; $display("FAIL rst_stall_after got busy=%h iv=%b rdy=%b instr=%h want 0 0 1 0",
                               bus.busy_regs, bus.issue_valid, bus.instr_ready, bus.issue_instr);
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        reset    = 1'b1;
        idle_inputs();
        test_reset();
        test_back_to_back();
        test_raw_stall();
        test_collision();
        test_flush();
        test_x0();
        test_reset_mid_stall();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
